// File: rtl/clock_pkg.sv
// Shared constants for the clock/alarm front end: FSM state encoding and
// default debounce/auto-repeat timing, in 1 kHz ticks.
package clock_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DB_PRESS = 3'd1;
  localparam logic [2:0] HELD     = 3'd2;
  localparam logic [2:0] REPEAT   = 3'd3;
  localparam logic [2:0] DB_REL   = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = IDLE,
    StDbPress = DB_PRESS,
    StHeld    = HELD,
    StRepeat  = REPEAT,
    StDbRel   = DB_REL
  } state_e;

  localparam int unsigned DEBOUNCE_MS     = 20;
  localparam int unsigned REPEAT_DELAY_MS = 500;
  localparam int unsigned REPEAT_RATE_MS  = 100;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
// The reset value is a parameter so idle-high (active-low) inputs come out of
// reset in their inactive state.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; synchronous reset to the inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_repeat_conditioner.sv
// Push-button conditioner: synchronise, debounce against the 1 kHz strobe,
// emit a step pulse on press and auto-repeat step pulses while held.
// Optional build macro RELEASE_PULSE_EN adds a release_pulse output that fires
// once when an accepted press is released.
module button_repeat_conditioner #(
  parameter int unsigned DEBOUNCE_MS     = clock_pkg::DEBOUNCE_MS,
  parameter int unsigned REPEAT_DELAY_MS = clock_pkg::REPEAT_DELAY_MS,
  parameter int unsigned REPEAT_RATE_MS  = clock_pkg::REPEAT_RATE_MS,
  parameter int unsigned CNT_W           = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1khz,
  input  logic btn_n,
  output logic btn_db_n,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic long_hold
`ifdef RELEASE_PULSE_EN
  ,
  output logic release_pulse
`endif
);

  import clock_pkg::*;

  // Terminal counts: a phase ends on the tick that finds cnt at these values.
  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(REPEAT_DELAY_MS - DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] RateLast = CNT_W'(REPEAT_RATE_MS - 1);

  logic             s_n;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             held_from_q;  // 1: DB_REL was entered from REPEAT

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_n),
    .q  (s_n)
  );

  // Saturating increment so the counter can never wrap.
  always_comb begin
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // Debounce/repeat FSM with all outputs registered; pulses default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      held_from_q   <= 1'b0;
      btn_db_n      <= 1'b1;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      step_pulse    <= 1'b0;
      long_hold     <= 1'b0;
`ifdef RELEASE_PULSE_EN
      release_pulse <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      step_pulse    <= 1'b0;
`ifdef RELEASE_PULSE_EN
      release_pulse <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          btn_db_n <= 1'b1;
          if (!s_n) begin
            state_q <= StDbPress;
            cnt_q   <= '0;
          end
        end
        StDbPress: begin
          // An input change beats a coincident tick.
          if (s_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (tick_1khz) begin
            if (cnt_q == DbLast) begin
              state_q     <= StHeld;
              cnt_q       <= '0;
              btn_db_n    <= 1'b0;
              press_pulse <= 1'b1;
              step_pulse  <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        StHeld: begin
          if (s_n) begin
            state_q     <= StDbRel;
            cnt_q       <= '0;
            held_from_q <= 1'b0;
          end else if (tick_1khz) begin
            if (cnt_q == HoldLast) begin
              state_q      <= StRepeat;
              cnt_q        <= '0;
              long_hold    <= 1'b1;
              repeat_pulse <= 1'b1;
              step_pulse   <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        StRepeat: begin
          if (s_n) begin
            state_q     <= StDbRel;
            cnt_q       <= '0;
            held_from_q <= 1'b1;
          end else if (tick_1khz) begin
            if (cnt_q == RateLast) begin
              cnt_q        <= '0;
              repeat_pulse <= 1'b1;
              step_pulse   <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        StDbRel: begin
          // Release bounce: resume the held phase with a fresh interval.
          if (!s_n) begin
            state_q <= held_from_q ? StRepeat : StHeld;
            cnt_q   <= '0;
          end else if (tick_1khz) begin
            if (cnt_q == DbLast) begin
              state_q       <= StIdle;
              cnt_q         <= '0;
              btn_db_n      <= 1'b1;
              long_hold     <= 1'b0;
`ifdef RELEASE_PULSE_EN
              release_pulse <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_repeat_conditioner.md
Name: button_repeat_conditioner

Overview:
Conditions one raw active-low push button before it reaches the clock/alarm preset logic.
- Synchronises the input and debounces it against the 1 kHz system strobe.
- Emits a single-cycle step pulse on press, then auto-repeat step pulses while the button is held, so one press or a long hold advances hour/minute registers.
- Sits between the board pins (BUT1/BUT2) and the time-keeping core; one instance per button.

Parameters:
DEBOUNCE_MS, 20, ticks the input must stay stable before a change is accepted (1..1023)
REPEAT_DELAY_MS, 500, ticks from accepted press to first auto-repeat (> DEBOUNCE_MS)
REPEAT_RATE_MS, 100, ticks between subsequent auto-repeats (>= 1)
CNT_W, 10, tick counter width; every *_MS parameter must fit in CNT_W bits

Ports:
clk  in  1  system clock (24 MHz)
rst  in  1  synchronous reset, active-high
tick_1khz  in  1  one-clk-wide strobe at 1 kHz, from the core divider
btn_n  in  1  raw button, active-low, asynchronous to clk
btn_db_n  out  1  debounced level, active-low
press_pulse  out  1  one clk high on accepted press
repeat_pulse  out  1  one clk high on each auto-repeat
step_pulse  out  1  press_pulse OR repeat_pulse
long_hold  out  1  high while held past REPEAT_DELAY_MS

Behaviour:
- Input path: btn_n passes a 2-FF synchroniser to give s_n. All state logic uses s_n. Synchroniser reset value is 1.
- Reset values: btn_db_n=1, press_pulse=0, repeat_pulse=0, step_pulse=0, long_hold=0, state=IDLE, cnt=0.
- All outputs are registered.
- cnt advances only on cycles where tick_1khz=1. Comparisons are unsigned, CNT_W bits. cnt never wraps; it holds at its terminal value.

FSM:
- IDLE: btn_db_n=1. If s_n=0 -> DB_PRESS with cnt=0.
- DB_PRESS:
  - If s_n=1 -> IDLE (bounce rejected, no pulse).
  - On a tick with cnt==DEBOUNCE_MS-1 -> HELD. Set btn_db_n=0 and press_pulse=1 for exactly one clk, in the cycle after that tick. Set cnt=0.
- HELD:
  - If s_n=1 -> DB_REL with cnt=0.
  - On a tick with cnt==REPEAT_DELAY_MS-DEBOUNCE_MS-1 -> REPEAT. Set long_hold=1, repeat_pulse=1 for one clk, cnt=0.
- REPEAT:
  - If s_n=1 -> DB_REL with cnt=0.
  - On a tick with cnt==REPEAT_RATE_MS-1, set repeat_pulse=1 for one clk and cnt=0.
- DB_REL:
  - If s_n=0, return to the state it came from (held_from flag), and cnt restarts at 0. A release bounce therefore restarts the repeat interval and produces no extra pulse.
  - On a tick with cnt==DEBOUNCE_MS-1 -> IDLE. Set btn_db_n=1, long_hold=0, cnt=0.

Boundary cases:
- s_n change and tick in the same cycle: the s_n change wins. The counter restarts and the tick is not counted.
- tick held high for multiple clks (misuse): each high cycle counts as a tick.
- REPEAT_RATE_MS=1: repeat_pulse fires on every tick while held.
- rst mid-hold: the FSM returns to IDLE with no pulse on the reset cycle. If the button is still low after reset, a full debounce and press_pulse occur again.
- press_pulse and repeat_pulse are never high in the same cycle.

Latency: btn_n falling to press_pulse = 2 clk synchroniser + DEBOUNCE_MS ticks + 1 clk.

Optional Feature:
RELEASE_PULSE_EN
- Defined: adds output port release_pulse (1 bit, reset 0). It goes high for one clk in the cycle the FSM goes DB_REL -> IDLE. It fires only if the press was accepted (DB_PRESS bounces never produce it).
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package clock_pkg holds:
  - state encoding localparams: IDLE=3'd0, DB_PRESS=3'd1, HELD=3'd2, REPEAT=3'd3, DB_REL=3'd4
  - default timing constants: DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS
- One sub-module, sync_2ff (parameterised reset value). The same synchroniser is reused for the swch inputs.

Test Plan:
Sim parameters: DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3; tick every 8 clk.
1. Clean press held 3 ticks, then released -> no pulses; btn_db_n stays 1.
2. Clean press held 6 ticks, then released -> exactly 1 press_pulse, 1 clk after the 4th tick; 0 repeat_pulse; btn_db_n=1 again 4 ticks after release.
3. Hold 19 ticks -> press_pulse at tick 4; repeat_pulse at ticks 10, 13, 16, 19; step_pulse count=5; long_hold=1 from tick 10.
4. Bounce pattern 0,1,0,1 per clk, then steady 0 -> debounce counts from the last edge; a single press_pulse; zero extra pulses.
5. Hold into REPEAT, assert rst for 1 clk at tick 12 -> all outputs 0/1 per reset; press_pulse re-fires 4 ticks later; with RELEASE_PULSE_EN, release_pulse=0 during reset.
6. With RELEASE_PULSE_EN, do case 2 -> release_pulse high exactly once, 4 ticks after release; case 1 -> release_pulse never high.
